me_frame_loader: RTL and testbench

//  Host-side initiator for the motion-estimation core. Accepts a valid/ready pixel stream and writes the
//  31x31 search window into the SW memory port, then the 16x16 reference block into the RB memory port.
//  It then runs the core via me_enable, waits for DONE and returns min SAD on a valid/ready result port.

---
 rtl/me_pkg.sv | 18 +
 rtl/me_frame_loader.sv | 116 +++++++++++
 tb/tb_me_frame_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// me_pkg: shared state encoding, memory depths and address widths for the ME frame loader
package me_pkg;

    localparam int SW_DEPTH = 961;
    localparam int RB_DEPTH = 256;
    localparam int SW_AW    = $clog2(SW_DEPTH);
    localparam int RB_AW    = $clog2(RB_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_SW,
        LOAD_RB,
        FLUSH,
        RUN,
        RESULT
    } state_t;

endpackage

// File: rtl/me_frame_loader.sv
// me_frame_loader: streams SW/RB pixels into the ME core memories, runs the core and returns min SAD
module me_frame_loader
    import me_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int SW_MEMORY_DEPTH = SW_DEPTH,
    parameter int RB_MEMORY_DEPTH = RB_DEPTH,
    parameter int MAX_DATA_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                               in_clk,
    input  logic                               in_rst,
    input  logic                               in_start,
    input  logic                               in_pix_valid,
    input  logic [DATA_WIDTH-1:0]              in_pix_data,
    output logic                               out_pix_ready,
    output logic                               out_sw_write_en,
    output logic [$clog2(SW_MEMORY_DEPTH)-1:0] out_sw_write_addr,
    output logic [DATA_WIDTH-1:0]              out_sw_write_data,
    output logic                               out_rb_write_en,
    output logic [$clog2(RB_MEMORY_DEPTH)-1:0] out_rb_write_addr,
    output logic [DATA_WIDTH-1:0]              out_rb_write_data,
    output logic                               out_me_enable,
    input  logic [MAX_DATA_WIDTH-1:0]          in_me_min_sad,
    input  logic                               in_me_done,
    output logic                               out_res_valid,
    input  logic                               in_res_ready,
    output logic [MAX_DATA_WIDTH-1:0]          out_res_sad,
    output logic                               out_res_timeout,
    output logic                               out_busy
);

    localparam int AW_SW = $clog2(SW_MEMORY_DEPTH);
    localparam int AW_RB = $clog2(RB_MEMORY_DEPTH);
    localparam int TW    = $clog2(TIMEOUT_CYCLES);

    state_t           state, next;
    logic [AW_SW-1:0] cnt;
    logic [TW-1:0]    tcnt;
    logic             done_q;
    logic             acc, sw_last, rb_last, done_edge, t_end;

    // Every output below decodes registered state only, so no input reaches an output combinationally.
    assign out_pix_ready = (state == LOAD_SW) || (state == LOAD_RB);
    assign out_me_enable = state == RUN;
    assign out_res_valid = state == RESULT;
    assign out_busy      = state != IDLE;

    assign acc       = in_pix_valid && out_pix_ready;
    assign sw_last   = cnt == AW_SW'(SW_MEMORY_DEPTH - 1);
    assign rb_last   = cnt == AW_SW'(RB_MEMORY_DEPTH - 1);
    assign done_edge = in_me_done && !done_q;
    assign t_end     = tcnt == TW'(TIMEOUT_CYCLES - 1);

    // State register
    always_ff @(posedge in_clk) begin
        if (!in_rst) state <= IDLE;
        else         state <= next;
    end

    // Next-state logic; a done edge and a timeout in the same RUN cycle both leave, the edge's SAD wins below
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_start ? LOAD_SW : IDLE;
            LOAD_SW: next = (acc && sw_last) ? LOAD_RB : LOAD_SW;
            LOAD_RB: next = (acc && rb_last) ? FLUSH : LOAD_RB;
            FLUSH:   next = RUN;
            RUN:     next = (done_edge || t_end) ? RESULT : RUN;
            RESULT:  next = in_res_ready ? IDLE : RESULT;
            default: next = IDLE;
        endcase
    end

    // Pixel counter, registered write ports, timeout counter, done edge detector and result capture
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            cnt               <= '0;
            tcnt              <= '0;
            done_q            <= 1'b0;
            out_sw_write_en   <= 1'b0;
            out_sw_write_addr <= '0;
            out_sw_write_data <= '0;
            out_rb_write_en   <= 1'b0;
            out_rb_write_addr <= '0;
            out_rb_write_data <= '0;
            out_res_sad       <= '0;
            out_res_timeout   <= 1'b0;
        end else begin
            done_q          <= in_me_done;
            out_sw_write_en <= acc && state == LOAD_SW;
            out_rb_write_en <= acc && state == LOAD_RB;
            if (acc && state == LOAD_SW) begin
                out_sw_write_addr <= cnt;
                out_sw_write_data <= in_pix_data;
            end
            if (acc && state == LOAD_RB) begin
                out_rb_write_addr <= cnt[AW_RB-1:0];
                out_rb_write_data <= in_pix_data;
            end
            if (state == IDLE)
                cnt <= '0;
            else if (acc)
                cnt <= ((state == LOAD_SW) ? sw_last : rb_last) ? '0 : cnt + 1'b1;
            tcnt <= (state == RUN) ? tcnt + 1'b1 : '0;
            if (state == RUN && done_edge) begin
                out_res_sad     <= in_me_min_sad;
                out_res_timeout <= 1'b0;
            end else if (state == RUN && t_end) begin
                out_res_sad     <= '1;
                out_res_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_me_frame_loader.sv
// tb_me_frame_loader: directed checks of load sequencing, run/result handshake, timeout and reset
module tb_me_frame_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_ready;
    logic        sw_we, rb_we;
    logic [9:0]  sw_addr;
    logic [7:0]  sw_data, rb_addr, rb_data;
    logic        me_en;
    logic [15:0] min_sad = '0;
    logic        done = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_sad;
    logic        res_to;
    logic        busy;

    int total = 0;
    int bad = 0;
    int sw_n, rb_n;

    always #5 clk = ~clk;

    me_frame_loader dut (
        .in_clk(clk),
        .in_rst(rst),
        .in_start(start),
        .in_pix_valid(pix_valid),
        .in_pix_data(pix_data),
        .out_pix_ready(pix_ready),
        .out_sw_write_en(sw_we),
        .out_sw_write_addr(sw_addr),
        .out_sw_write_data(sw_data),
        .out_rb_write_en(rb_we),
        .out_rb_write_addr(rb_addr),
        .out_rb_write_data(rb_data),
        .out_me_enable(me_en),
        .in_me_min_sad(min_sad),
        .in_me_done(done),
        .out_res_valid(res_valid),
        .in_res_ready(res_ready),
        .out_res_sad(res_sad),
        .out_res_timeout(res_to),
        .out_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers n pixels (value = addr & 0xFF) with gap_pct% idle cycles and checks every write strobe
    task automatic load(input int n, input int gap_pct);
        int sent = 0;
        int guard = 0;
        logic [1:0] exp_we;
        sw_n = 0;
        rb_n = 0;
        while (sent < n && guard < 20000) begin
            pix_valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
            pix_data = 8'(sent < 961 ? sent : sent - 961);
            exp_we = !pix_valid ? 2'b00 : (sent < 961 ? 2'b10 : 2'b01);
            check("load_ready", pix_ready, 1);
            tick;
            guard++;
            check("write_kind", {sw_we, rb_we}, exp_we);
            if (sw_we) begin
                check("sw_addr", sw_addr, sw_n);
                check("sw_data", sw_data, sw_n & 255);
                sw_n++;
            end
            if (rb_we) begin
                check("rb_addr", rb_addr, rb_n);
                check("rb_data", rb_data, rb_n & 255);
                rb_n++;
            end
            if (pix_valid) sent++;
        end
        pix_valid = 1'b0;
        check("load_sent", sent, n);
    endtask

    initial begin
        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_we", {sw_we, rb_we}, 0);
        check("rst_valid", res_valid, 0);
        check("rst_me_en", me_en, 0);
        check("rst_sad", res_sad, 0);
        rst = 1'b1;

        pix_valid = 1'b1;
        pix_data = 8'h55;
        repeat (3) begin
            tick;
            check("idle_ready", pix_ready, 0);
            check("idle_we", {sw_we, rb_we}, 0);
        end
        check("idle_busy", busy, 0);
        pix_valid = 1'b0;

        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_busy", busy, 1);
        load(500, 0);
        check("pre_rst_we", sw_we, 1);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("mid_rst_we", sw_we, 0);
        check("mid_rst_addr", sw_addr, 0);
        check("mid_rst_data", sw_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", pix_ready, 0);

        start = 1'b1;
        tick;
        start = 1'b0;
        load(1217, 0);
        check("full_sw_count", sw_n, 961);
        check("full_rb_count", rb_n, 256);
        check("flush_me_en", me_en, 0);
        tick;
        check("run_me_en", me_en, 1);
        repeat (9) tick;
        done = 1'b1;
        min_sad = 16'h01A3;
        check("run10_valid", res_valid, 0);
        tick;
        check("res_valid", res_valid, 1);
        check("res_sad", res_sad, 16'h01A3);
        check("res_timeout", res_to, 0);
        check("res_me_en", me_en, 0);
        min_sad = 16'h0BAD;
        repeat (5) begin
            start = 1'b1;
            tick;
            check("hold_valid", res_valid, 1);
            check("hold_sad", res_sad, 16'h01A3);
            check("hold_timeout", res_to, 0);
        end
        res_ready = 1'b1;
        tick;
        start = 1'b0;
        res_ready = 1'b0;
        check("hs_valid", res_valid, 0);
        check("hs_busy", busy, 0);
        tick;
        check("hs_start_ignored", busy, 0);

        start = 1'b1;
        tick;
        load(1217, 30);
        start = 1'b0;
        check("gap_sw_count", sw_n, 961);
        check("gap_rb_count", rb_n, 256);
        check("gap_flush_me_en", me_en, 0);
        tick;
        check("gap_run_me_en", me_en, 1);
        repeat (4095) tick;
        check("to_last_run_valid", res_valid, 0);
        check("to_last_run_me_en", me_en, 1);
        tick;
        check("to_valid", res_valid, 1);
        check("to_sad", res_sad, 16'hFFFF);
        check("to_flag", res_to, 1);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        done = 1'b0;
        check("to_hs_busy", busy, 0);

        start = 1'b1;
        tick;
        start = 1'b0;
        load(1217, 0);
        tick;
        check("tie_run_me_en", me_en, 1);
        repeat (4095) tick;
        done = 1'b1;
        min_sad = 16'h0042;
        tick;
        check("tie_valid", res_valid, 1);
        check("tie_sad", res_sad, 16'h0042);
        check("tie_flag", res_to, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check("tie_hs_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
